// File: rtl/fifo_rd_fwft_if.sv
// Read-side FIFO bundle: upstream pop/empty/rdata and the downstream valid/ready stream.
interface fifo_rd_fwft_if #(
    parameter int unsigned DWIDTH = 8
);
    logic              empty;
    logic              pop;
    logic [DWIDTH-1:0] rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic [1:0]        occupancy;

    // Output stage side: consumes RAM words, produces the stream.
    modport master (
        input  empty,
        input  rdata,
        input  m_ready,
        output pop,
        output m_valid,
        output m_data,
        output occupancy
    );

    // Environment side: read controller, RAM and downstream consumer.
    modport slave (
        output empty,
        output rdata,
        output m_ready,
        input  pop,
        input  m_valid,
        input  m_data,
        input  occupancy
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through output stage for the async FIFO read side.
// A 2-entry buffer plus an in-flight flag turns pop/empty and 1-cycle RAM
// read data into a valid/ready stream at full rate without dropping words.
module fifo_rd_fwft #(
    parameter int unsigned DWIDTH = 8
) (
    input  logic           rclk,
    input  logic           reset_L,
    fifo_rd_fwft_if.master bus
);
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [CNT_W-1:0]  held_q, held_d;
    logic              inflight_q, inflight_d;
    logic [DWIDTH-1:0] buf0_q, buf0_d;
    logic [DWIDTH-1:0] buf1_q, buf1_d;
    logic              take;
    logic              pop_c;
    logic [SUM_W-1:0]  credit;
    logic [CNT_W-1:0]  wr_pos;

    // State registers: held words, in-flight flag, 2-entry buffer (buf0 is head).
    always_ff @(posedge rclk or negedge reset_L) begin
        if (!reset_L) begin
            held_q     <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            held_q     <= held_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    // Credit-based pop, head shift on take, capture of in-flight word behind held ones.
    always_comb begin
        take       = 1'b0;
        credit     = '0;
        pop_c      = 1'b0;
        held_d     = held_q;
        inflight_d = 1'b0;
        wr_pos     = '0;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;

        take = (held_q != CNT_W'(0)) && bus.m_ready;
        // 3-bit sum: take implies held >= 1, so this never wraps.
        credit = SUM_W'(held_q) + SUM_W'(inflight_q) - SUM_W'(take);
        pop_c  = reset_L && !bus.empty && (credit < SUM_W'(2));

        inflight_d = pop_c;
        held_d     = credit[CNT_W-1:0];

        if (take) begin
            buf0_d = buf1_q;
        end
        wr_pos = held_q - CNT_W'(take);
        if (inflight_q) begin
            if (wr_pos == CNT_W'(0)) begin
                buf0_d = bus.rdata;
            end else begin
                buf1_d = bus.rdata;
            end
        end
    end

    assign bus.pop       = pop_c;
    assign bus.m_valid   = (held_q != CNT_W'(0));
    assign bus.m_data    = buf0_q;
    assign bus.occupancy = held_q;
endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
Read-side output stage of the async FIFO, clocked in the read domain, sitting directly downstream of the read controller and the dual-port RAM read port.
- Turns the pop/empty interface plus the RAM's 1-cycle synchronous read data into a first-word-fall-through valid/ready stream.
- Holds up to 2 words in a local buffer, so it sustains 1 word/cycle under no backpressure and never loses a word under backpressure.

Parameters:
DWIDTH, 8, data word width.

Ports:
rclk  input  1  read-domain clock.
reset_L  input  1  asynchronous active-low reset.
empty  input  1  FIFO empty flag from the read controller.
pop  output  1  read request to the read controller; a pop is counted only when pop && !empty.
rdata  input  DWIDTH  RAM read data; valid in the cycle after an accepted pop.
m_valid  output  1  head word present on m_data.
m_ready  input  1  downstream accept.
m_data  output  DWIDTH  head word (oldest held word).
occupancy  output  2  number of words held in the local buffer (0..2).

Behaviour:
- Reset (reset_L low, asynchronous):
  - held count = 0, in-flight flag = 0.
  - m_valid = 0, occupancy = 0, m_data = 0.
  - pop is forced to 0 while reset_L is low, regardless of empty. The upstream controller drives empty = 0 during reset, so this gating is mandatory.
- Definitions:
  - take = m_valid && m_ready.
  - acc = pop && !empty.
  - inflight = registered flag, set at the edge where acc = 1, else cleared.
- pop (combinational) = reset_L && !empty && ((held + inflight - take) < 2).
  - The path from m_ready to pop is combinational and intended; it is what gives full throughput.
- Capture:
  - When inflight = 1, rdata is written into the buffer at the next rclk edge, behind any held words.
  - The credit rule above guarantees the buffer never overflows; the bench asserts this.
- Head and ordering:
  - m_valid = (held != 0).
  - m_data = oldest held word, registered, with no combinational path from rdata.
  - take removes the head at the edge; the next-oldest word becomes head in the following cycle.
- Simultaneous take and capture: held is unchanged and the order is preserved.
- m_data must stay stable while m_valid && !m_ready.
- Latency:
  - empty falls in cycle C (idle buffer), so pop = 1 in C.
  - inflight = 1 in C+1.
  - Word captured at the edge ending C+1; m_valid = 1 in C+2.
- Throughput:
  - With m_ready held high and empty low, pop stays high every cycle.
  - Steady state: held = 1, inflight = 1, m_valid continuously high.
- Backpressure:
  - m_ready low: pop stops once held + inflight = 2.
  - No word is dropped or duplicated.
- empty rising while a word is in flight: that word is still captured. pop drops with empty.
- Reset mid-operation: held words and the in-flight word are discarded, and all outputs return to reset values asynchronously.
- Arithmetic: held + inflight is computed at 3 bits, so the subtraction of take cannot underflow (take implies held ≥ 1).

Test Plan:
- Reset: reset_L low with empty = 0 -> pop = 0, m_valid = 0, occupancy = 0. Release reset -> outputs still 0 until empty falls.
- Single word: load 0xA5, empty falls in cycle C with m_ready = 1 -> pop = 1 in C only, m_valid = 1 with m_data = 0xA5 in C+2, accepted in C+2, m_valid = 0 in C+3.
- Streaming: 16 words 0x00..0x0F available, m_ready = 1 -> pop high 16 consecutive cycles, m_valid high 16 consecutive cycles from C+2, data in order, no gaps.
- Backpressure: stream 8 words, m_ready = 0 for 5 cycles mid-stream -> occupancy saturates at 2, pop = 0 while held + inflight = 2, m_data stable, all 8 words received in order exactly once.
- empty races: empty low for exactly one cycle (one word) then high -> exactly one pop, one word delivered, no spurious m_valid.
- Reset mid-stream: assert reset_L with occupancy = 2 and inflight = 1 -> m_valid, occupancy, pop = 0 immediately. After release, the first delivered word is the next word from the FIFO, not any pre-reset word.
